regfile_sweep: RTL and testbench
================================

# regfile_sweep

Parametrised multi-port register file, the next-generation general-purpose register store for the CPU datapath. It has configurable width and depth, two registered read ports with write-to-read forwarding, and one write port. A hardware clear sequencer zeroes every entry one per cycle after reset or on a soft-clear request, and holds the file busy until the sweep completes.

## Interface
- DATA_W, 8, data width in bits (≥1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 1)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- clr  input  1  soft-clear request, sampled when not busy
- rd_en_a  input  1  read request, port A
- rd_addr_a  input  ADDR_W  read address, port A
- rd_en_b  input  1  read request, port B
- rd_addr_b  input  ADDR_W  read address, port B
- we  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd_data_a  output  DATA_W  registered read data, port A
- rd_valid_a  output  1  rd_data_a valid (one-cycle pulse)
- rd_data_b  output  DATA_W  registered read data, port B
- rd_valid_b  output  1  rd_data_b valid (one-cycle pulse)
- busy  output  1  sweep in progress; writes not accepted
- wr_drop  output  1  one-cycle pulse: a requested write was discarded

## Operation
- States: SWEEP, RUN. The sweep pointer is ADDR_W bits.
- Reset (asynchronous): state=SWEEP, ptr=0, rd_data_a/b=0, rd_valid_a/b=0, wr_drop=0, busy=1. Memory contents are not reset directly.
- SWEEP: each edge writes 0 to mem[ptr], then ptr++. The edge that clears mem[DEPTH-1] moves to RUN and resets ptr to 0. clr is ignored in SWEEP; the sweep never restarts.
- RUN + clr=1: next state is SWEEP with ptr=0. Any write in the same cycle is discarded (clr wins) and wr_drop pulses.
- RUN + clr=0 + we=1: mem[wr_addr] <= wr_data.
- we=1 while busy: write discarded, wr_drop=1 on the next cycle.
- Read, per port independently: when rd_en=1, rd_data and rd_valid update on the next edge. When rd_en=0, rd_valid=0 and rd_data holds its previous value.
  - Busy: data returned is 0.
  - RUN, write accepted in the same cycle to the same address: data returned is wr_data (write-first forwarding).
  - RUN, otherwise: data returned is mem[addr].
  - RUN with clr=1 in the same cycle: the read returns pre-clear contents. No forwarding applies, because the write is dropped.
- Both ports may read the same address in the same cycle; both return identical data.
- busy = (state == SWEEP), driven directly from the state register.

## Timing
- Read latency: 1 cycle, with full throughput on both ports every cycle.
- Write: visible to a read issued in the same cycle (forwarded) and to every later read.
- Sweep: exactly DEPTH cycles.
  - After reset deassertion, busy falls after the DEPTH-th rising edge.
  - The first write is accepted at edge DEPTH+1.
  - clr asserted in RUN at edge N gives busy=1 from edge N to edge N+DEPTH.
- wr_drop: registered, asserted for the cycle after the dropped request.
- Reset mid-sweep or mid-read: immediate return to reset values, and the sweep restarts from ptr=0.

## Configuration
- REGFILE_ZERO_REG_EN defined: entry 0 is hardwired zero.
  - Reads of address 0 always return 0.
  - Writes to address 0 are silently discarded, with no forwarding and no wr_drop.
  - Storage for entry 0 may be omitted.
- REGFILE_ZERO_REG_EN undefined: entry 0 is an ordinary register.

## Test plan
- Reset, then hold rd_en_a=1 with rd_addr_a=3 → busy=1 for 4 edges, rd_data_a=0 throughout, busy=0 after edge 4.
- After the sweep, write 0xA5 to addr 2, then read addr 2 on both ports next cycle → rd_data_a=rd_data_b=0xA5, rd_valid_a/b pulse once.
- Same cycle: we=1 (addr 1, 0x3C) and rd_en_a=1 (addr 1) → rd_data_a=0x3C one cycle later (forwarding).
- Fill addrs 0–3 with 0x11/0x22/0x33/0x44, then pulse clr with we=1 (addr 3, 0xFF) and rd_en_b=1 (addr 3).
  - Expect rd_data_b=0x44 and wr_drop=1 next cycle, busy=1 for 4 cycles.
  - After the sweep, all reads return 0.
- Assert reset during a sweep at ptr=2 → all outputs return to reset values immediately; a full 4-cycle sweep follows deassertion.
- With REGFILE_ZERO_REG_EN: write 0x77 to addr 0 and read addr 0 in the same cycle and the next → rd_data=0 both times, wr_drop=0.

Source files
------------

// File: rtl/regfile_sweep.sv
// ---------------------------------------------------------------------------
// regfile_sweep
//
// Parametrised register file with two registered read ports, one write port
// and a hardware clear sequencer. After reset, or on a soft-clear request,
// the sequencer writes zero to one entry per cycle. The file reports busy
// until every entry has been cleared.
//
// Parameters
//   DATA_W      data width in bits (>= 1)
//   ADDR_W      address width; DEPTH = 2**ADDR_W entries (>= 1)
//
// Ports
//   clk         clock; all state updates happen on the rising edge
//   reset       asynchronous, active-high reset
//   clr         soft-clear request; ignored while busy
//   rd_en_a     read request, port A
//   rd_addr_a   read address, port A
//   rd_en_b     read request, port B
//   rd_addr_b   read address, port B
//   we          write request
//   wr_addr     write address
//   wr_data     write data
//   rd_data_a   registered read data, port A (holds its value when not read)
//   rd_valid_a  one-cycle pulse marking rd_data_a as valid
//   rd_data_b   registered read data, port B (holds its value when not read)
//   rd_valid_b  one-cycle pulse marking rd_data_b as valid
//   busy        a clear sweep is in progress; writes are not accepted
//   wr_drop     one-cycle pulse; the write requested last cycle was discarded
//
// Build option
//   REGFILE_ZERO_REG_EN  when defined, entry 0 is hardwired to zero. Reads of
//                        address 0 return 0. Writes to address 0 are ignored
//                        without forwarding and without a wr_drop pulse.
// ---------------------------------------------------------------------------
module regfile_sweep #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    output logic              busy,
    output logic              wr_drop
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single storage write port, shared by the sweep and by normal writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              wr_to_zero;   // write aimed at the hardwired zero entry
    logic              wr_accept;    // write lands this cycle (RUN, no clr)
    logic              drop_now;     // write requested but discarded this cycle

    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;

    assign wr_to_zero = ZERO_REG && (wr_addr == '0);

    // -----------------------------------------------------------------------
    // Sequencer next-state logic and storage write steering
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves a value unassigned and no latch
    // is inferred. Blocking '=' is correct here because this is combinational.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        wr_accept  = 1'b0;
        drop_now   = 1'b0;

        case (state)
            SWEEP: begin
                // One entry is cleared per edge. clr is ignored, so a sweep
                // in progress never restarts.
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = '0;
                next_ptr  = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    next_state = RUN;
                    next_ptr   = '0;
                end
                drop_now = we && !wr_to_zero;
            end

            RUN: begin
                if (clr) begin
                    // A clear takes priority over a write in the same cycle.
                    next_state = SWEEP;
                    next_ptr   = '0;
                    drop_now   = we && !wr_to_zero;
                end else if (we && !wr_to_zero) begin
                    wr_accept = 1'b1;
                    mem_we    = 1'b1;
                end
            end

            default: begin
                next_state = SWEEP;
                next_ptr   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read data selection (one independent mux per port)
    // -----------------------------------------------------------------------
    // During a sweep every read returns zero, which matches the contents once
    // the sweep finishes. In RUN, a write accepted this cycle to the same
    // address is forwarded (write-first). wr_accept is already low when clr
    // is high, so a read that coincides with a clear returns pre-clear data.
    always_comb begin
        read_a = mem[rd_addr_a];
        if (state == SWEEP) begin
            read_a = '0;
        end else if (ZERO_REG && (rd_addr_a == '0)) begin
            read_a = '0;
        end else if (wr_accept && (wr_addr == rd_addr_a)) begin
            read_a = wr_data;
        end
    end

    always_comb begin
        read_b = mem[rd_addr_b];
        if (state == SWEEP) begin
            read_b = '0;
        end else if (ZERO_REG && (rd_addr_b == '0)) begin
            read_b = '0;
        end else if (wr_accept && (wr_addr == rd_addr_b)) begin
            read_b = wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so that every register
    // samples its inputs from before the edge, whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset branch. Clearing happens through the sweep
    // one entry per cycle. This keeps the array mappable onto plain flops or
    // a RAM macro without a reset fan-out to every bit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read ports and write-drop flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= read_a;
            end
            if (rd_en_b) begin
                rd_data_b <= read_b;
            end
            wr_drop <= drop_now;
        end
    end

    assign busy = (state == SWEEP);

endmodule

// File: tb/tb_regfile_sweep.sv
// ---------------------------------------------------------------------------
// tb_regfile_sweep
//
// Self-checking bench for regfile_sweep with default parameters (8-bit data,
// 4 entries). The stimulus process drives inputs on the falling edge and
// pushes the expected post-edge outputs into a scoreboard queue. The monitor
// pops one entry just after each rising edge and compares it with the DUT.
// The reference model tracks the remaining sweep cycles as a count and keeps
// the file contents in a plain array.
// ---------------------------------------------------------------------------
module tb_regfile_sweep;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              clr;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              busy;
    logic              wr_drop;

    regfile_sweep #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .busy       (busy),
        .wr_drop    (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              busy;
        logic              drop;
        logic              va;
        logic [DATA_W-1:0] da;
        logic              vb;
        logic [DATA_W-1:0] db;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                sweep_left;
    logic [DATA_W-1:0] last_a;
    logic [DATA_W-1:0] last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        last_a     = '0;
        last_b     = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    function automatic bit is_zero_reg(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
        return a == '0;
`else
        return 1'b0;
`endif
    endfunction

    // Value a read of addr returns, given the inputs currently driven.
    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] addr);
        if (sweep_left > 0) return '0;
        if (is_zero_reg(addr)) return '0;
        if (we && !clr && !is_zero_reg(wr_addr) && wr_addr == addr) return wr_data;
        return m_mem[addr];
    endfunction

    // Called at a falling edge: drives one cycle of inputs, queues the
    // expected outputs after the next rising edge, advances the model, and
    // returns at the following falling edge.
    task automatic step(input logic c, input logic ea, input logic [ADDR_W-1:0] aa,
                        input logic eb, input logic [ADDR_W-1:0] ab,
                        input logic w, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd);
        exp_t e;
        bit   was_busy;
        clr = c; rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        we = w; wr_addr = wa; wr_data = wd;
        was_busy = (sweep_left > 0);

        if (ea) last_a = model_read(aa);
        if (eb) last_b = model_read(ab);
        e.va   = ea;
        e.da   = last_a;
        e.vb   = eb;
        e.db   = last_b;
        e.drop = w && (was_busy || c) && !is_zero_reg(wa);

        if (was_busy) begin
            sweep_left--;
        end else if (c) begin
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (w && !is_zero_reg(wa)) begin
            m_mem[wa] = wd;
        end
        e.busy = (sweep_left > 0);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},    busy,       1);
        check({tag, "_drop"},    wr_drop,    0);
        check({tag, "_valid_a"}, rd_valid_a, 0);
        check({tag, "_valid_b"}, rd_valid_b, 0);
        check({tag, "_data_a"},  rd_data_a,  0);
        check({tag, "_data_b"},  rd_data_b,  0);
    endtask

    // Monitor: compare the DUT against the scoreboard just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("busy",       busy,       e.busy);
            check("wr_drop",    wr_drop,    e.drop);
            check("rd_valid_a", rd_valid_a, e.va);
            check("rd_data_a",  rd_data_a,  e.da);
            check("rd_valid_b", rd_valid_b, e.vb);
            check("rd_data_b",  rd_data_b,  e.db);
        end
    end

    initial begin
        reset = 1'b1;
        clr = 1'b0; rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        we = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #2;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // Sweep after reset: read addr 3 every cycle; busy for DEPTH edges,
        // and a write attempted during the sweep is dropped.
        step(1'b0, 1'b1, 2'd3, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 2'd3, 1'b0, '0, 1'b1, 2'd1, 8'h99);
        step(1'b0, 1'b1, 2'd3, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 2'd3, 1'b0, '0, 1'b0, '0, '0);

        // Write then read the same address on both ports.
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd2, 8'hA5);
        step(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, '0, '0);
        idle();

        // Same-cycle write and read: forwarding.
        step(1'b0, 1'b1, 2'd1, 1'b0, '0, 1'b1, 2'd1, 8'h3C);
        step(1'b0, 1'b0, '0, 1'b1, 2'd1, 1'b0, '0, '0);

        // Fill, then clear with a colliding write and read.
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd0, 8'h11);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd1, 8'h22);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd2, 8'h33);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd3, 8'h44);
        step(1'b1, 1'b0, '0, 1'b1, 2'd3, 1'b1, 2'd3, 8'hFF);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i[ADDR_W-1:0], 1'b1, i[ADDR_W-1:0], 1'b0, '0, '0);

        // Reset in the middle of a sweep (pointer at 2), with a read pending.
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 1'b1, 2'd0, 8'h5A);
        reset = 1'b1;
        #1;
        check_reset_values("mid_sweep_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'd0, 8'h66);
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, '0, '0);

`ifdef REGFILE_ZERO_REG_EN
        // Entry 0 stays zero; the write is ignored without a drop pulse.
        step(1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b1, 2'd0, 8'h77);
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, '0, '0);
`endif

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 9) < 7), 2'($urandom),
                 1'($urandom_range(0, 9) < 7), 2'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
        end
        idle();

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
